// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch constants,
// fetch-state encoding and PC helpers.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, flush-to-bubble
// or hold; reset value is a bubble.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, memory request
// handshake, stall buffering and redirect discard.
module if_stage #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  tgt_in;
  logic [31:0]  pc_plus4;
  logic [31:0]  ld_word;
  logic         load;
  logic         flush;

  assign tgt_in   = word_align(redirect_pc);
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    load    = 1'b0;
    flush   = 1'b0;
    ld_word = imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          flush = 1'b1;
          if (imem_ready) begin
            pc_d = tgt_in;
          end else begin
            tgt_d   = tgt_in;
            state_d = DISCARD;
          end
        end else if (imem_ready) begin
          if (stall) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            load = 1'b1;
            pc_d = pc_plus4;
          end
        end else begin
          flush = !stall;
        end
      end
      HOLD: begin
        ld_word = buf_q;
        if (redirect) begin
          flush   = 1'b1;
          pc_d    = tgt_in;
          state_d = FETCH;
        end else if (!stall) begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        // returned word is for the old path; only bubbles leave
        flush = redirect || !stall;
        if (imem_ready) begin
          pc_d    = redirect ? tgt_in : tgt_q;
          state_d = FETCH;
        end else if (redirect) begin
          tgt_d = tgt_in;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = pc_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .flush_i(flush),
    .instr_i(ld_word),
    .pc4_i  (pc_plus4),
    .instr_o(instr),
    .pc4_o  (pc_plus4_out),
    .valid_o(valid_out)
  );

endmodule
